// File: rtl/master_game_sm_if.sv
// Game-controller bus: buttons and maze status in, master state, timer and LEDs out.
interface master_game_sm_if;
    logic       BTNU;
    logic       BTND;
    logic [3:0] MAZE_STATE_IN;
    logic [1:0] MASTER_STATE;
    logic       SUB_RESET;
    logic [7:0] TIME_LEFT;
    logic       WIN_LED;
    logic       LOSE_LED;

    modport master (
        output BTNU, BTND, MAZE_STATE_IN,
        input  MASTER_STATE, SUB_RESET, TIME_LEFT, WIN_LED, LOSE_LED
    );

    modport slave (
        input  BTNU, BTND, MAZE_STATE_IN,
        output MASTER_STATE, SUB_RESET, TIME_LEFT, WIN_LED, LOSE_LED
    );
endinterface

// File: rtl/master_game_sm.sv
// Top-level game controller: IDLE/PLAY/WIN/LOSE sequencing, countdown timer,
// maze sub-FSM clear pulse and result LEDs, all outputs registered.
module master_game_sm #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned TIME_LIMIT  = 60,
    parameter int unsigned WIN_HOLD    = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    master_game_sm_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

    localparam int unsigned HOLD_CYCLES = WIN_HOLD * TICK_CYCLES;
    localparam int          TICK_W      = $clog2(TICK_CYCLES);
    localparam int          HOLD_W      = $clog2(HOLD_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]        TL_INIT   = 8'(TIME_LIMIT);

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        r_time_left;
    logic              r_sub_reset;
    logic              r_win_led;
    logic              r_lose_led;
    logic              r_btnu_q;
    logic              r_btnd_q;

    logic w_btnu_rise;
    logic w_btnd_rise;
    logic w_tick_done;
    logic w_maze_done;

    assign w_btnu_rise = bus.BTNU & ~r_btnu_q;
    assign w_btnd_rise = bus.BTND & ~r_btnd_q;
    assign w_tick_done = (r_tick == TICK_LAST);
    assign w_maze_done = (bus.MAZE_STATE_IN == 4'hF);

    assign bus.MASTER_STATE = r_state;
    assign bus.SUB_RESET    = r_sub_reset;
    assign bus.TIME_LEFT    = r_time_left;
    assign bus.WIN_LED      = r_win_led;
    assign bus.LOSE_LED     = r_lose_led;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_hold      <= '0;
            r_time_left <= TL_INIT;
            r_sub_reset <= 1'b0;
            r_win_led   <= 1'b0;
            r_lose_led  <= 1'b0;
            r_btnu_q    <= 1'b0;
            r_btnd_q    <= 1'b0;
        end else begin
            r_btnu_q    <= bus.BTNU;
            r_btnd_q    <= bus.BTND;
            r_sub_reset <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_time_left <= TL_INIT;
                    r_tick      <= '0;
                    if (w_btnu_rise) begin
                        r_state     <= PLAY;
                        r_sub_reset <= 1'b1;
                    end
                end

                PLAY: begin
                    r_tick <= w_tick_done ? '0 : r_tick + TICK_W'(1);
                    // The maze may still report its finished code from the previous game
                    // during the clear cycle, so the win check waits one cycle.
                    if (!r_sub_reset && w_maze_done) begin
                        r_state   <= WIN;
                        r_win_led <= 1'b1;
                        r_hold    <= '0;
                    end else if (w_btnd_rise) begin
                        r_state     <= IDLE;
                        r_time_left <= TL_INIT;
                    end else if (w_tick_done) begin
                        if (r_time_left == 8'd1) begin
                            r_time_left <= 8'd0;
                            r_state     <= LOSE;
                            r_lose_led  <= 1'b1;
                        end else if (r_time_left != 8'd0) begin
                            r_time_left <= r_time_left - 8'd1;
                        end
                    end
                end

                WIN: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state     <= IDLE;
                        r_win_led   <= 1'b0;
                        r_time_left <= TL_INIT;
                        r_hold      <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end

                LOSE: begin
                    r_time_left <= 8'd0;
                    if (w_btnu_rise) begin
                        r_state     <= IDLE;
                        r_lose_led  <= 1'b0;
                        r_time_left <= TL_INIT;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_game_sm.sv
// Scoreboard bench for master_game_sm with TICK_CYCLES=4, TIME_LIMIT=3, WIN_HOLD=2;
// stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_master_game_sm;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_WIN  = 2'b10;
    localparam logic [1:0] S_LOSE = 2'b11;

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    master_game_sm_if bus();

    master_game_sm #(
        .TICK_CYCLES (4),
        .TIME_LIMIT  (3),
        .WIN_HOLD    (2)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] dut_out();
        return {bus.MASTER_STATE, bus.SUB_RESET, bus.TIME_LEFT, bus.WIN_LED, bus.LOSE_LED};
    endfunction

    function automatic logic [12:0] pack(input logic [1:0] st, input logic sr, input int tl,
                                         input logic w, input logic l);
        return {st, sr, 8'(tl), w, l};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("st=%b sr=%b tl=%0d win=%b lose=%b", v[12:11], v[10], v[9:2], v[1], v[0]);
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    // Expected countdown value during PLAY cycle k (k=1 is the SUB_RESET cycle).
    function automatic int tl_at(input int k);
        return 3 - (k - 1) / 4;
    endfunction

    // Drive inputs for one cycle and queue the outputs expected after the next edge.
    task automatic cyc(input logic u, input logic d, input logic [3:0] m, input string name,
                       input logic [1:0] st, input logic sr, input int tl,
                       input logic w, input logic l);
        exp_t e;
        @(negedge clk);
        bus.BTNU          = u;
        bus.BTND          = d;
        bus.MAZE_STATE_IN = m;
        e.name = name;
        e.v    = pack(st, sr, tl, w, l);
        q.push_back(e);
    endtask

    // Seven more WIN cycles with button presses that must be ignored, then auto-return.
    task automatic win_hold(input int tl);
        for (int i = 2; i <= 8; i++)
            cyc(i == 2, i == 3, 4'h0, $sformatf("win_hold_%0d", i), S_WIN, 1'b0, tl, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, "win_exit", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.name, dut_out(), e.v);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        bus.BTNU          = 1'b0;
        bus.BTND          = 1'b0;
        bus.MAZE_STATE_IN = 4'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check("reset_vals", dut_out(), pack(S_IDLE, 1'b0, 3, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start, held BTNU, then timeout into LOSE.
        cyc(1'b0, 1'b0, 4'h0, "idle", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, "start", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        for (int k = 2; k <= 13; k++)
            cyc(k <= 10, 1'b0, 4'h0, $sformatf("timeout_c%0d", k), (k <= 12) ? S_PLAY : S_LOSE,
                1'b0, (k <= 12) ? tl_at(k) : 0, 1'b0, k == 13);
        cyc(1'b0, 1'b0, 4'h0, "lose_wait", S_LOSE, 1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 4'h0, "lose_btnd", S_LOSE, 1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, "lose_ack", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, "idle_held", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, "idle_rel", S_IDLE, 1'b0, 3, 1'b0, 1'b0);

        // Win at PLAY cycle 6: time frozen at 2, eight WIN cycles, back to IDLE.
        cyc(1'b1, 1'b0, 4'h0, "win_start", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        for (int k = 2; k <= 6; k++)
            cyc(1'b0, 1'b0, 4'h0, $sformatf("win_play_c%0d", k), S_PLAY, 1'b0, tl_at(k), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, "win_enter", S_WIN, 1'b0, 2, 1'b1, 1'b0);
        win_hold(2);

        // Stale finished code during the clear cycle, then F on the final tick.
        cyc(1'b1, 1'b0, 4'hF, "stale_start", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, "stale_f", S_PLAY, 1'b0, 3, 1'b0, 1'b0);
        for (int k = 3; k <= 12; k++)
            cyc(1'b0, 1'b0, 4'h0, $sformatf("stale_play_c%0d", k), S_PLAY, 1'b0, tl_at(k), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, "f_final_tick", S_WIN, 1'b0, 1, 1'b1, 1'b0);
        win_hold(1);

        // Abort with BTND at PLAY cycle 5; BTND ignored in IDLE.
        cyc(1'b1, 1'b0, 4'h0, "abort_start", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        for (int k = 2; k <= 5; k++)
            cyc(1'b0, 1'b0, 4'h0, $sformatf("abort_play_c%0d", k), S_PLAY, 1'b0, tl_at(k), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'h0, "abort", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'h0, "idle_btnd", S_IDLE, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, "idle_btnd_rel", S_IDLE, 1'b0, 3, 1'b0, 1'b0);

        // Asynchronous reset at PLAY cycle 7, BTNU held through it.
        cyc(1'b1, 1'b0, 4'h0, "rst_start", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        for (int k = 2; k <= 7; k++)
            cyc(1'b0, 1'b0, 4'h0, $sformatf("rst_play_c%0d", k), S_PLAY, 1'b0, tl_at(k), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        bus.BTNU = 1'b1;
        #1 check("async_reset", dut_out(), pack(S_IDLE, 1'b0, 3, 1'b0, 1'b0));
        @(posedge clk);
        #2 check("reset_hold", dut_out(), pack(S_IDLE, 1'b0, 3, 1'b0, 1'b0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 4'h0, "rst_hist", S_PLAY, 1'b1, 3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'h0, "post_rst_abort", S_IDLE, 1'b0, 3, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
